// File: rtl/boot_pkg.sv
// Shared types and constants for the SUBLEQ program loader.
// Imported by byte_packer and boot_loader.
package boot_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    S_HDR,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_CHECK,
    S_RUN,
    S_ERR
  } state_e;

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word assembler for the loader.
// word shows the value including the byte landing this cycle.
module byte_packer
  import boot_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              clear,
  output logic [WORD_W-1:0] word,
  output logic              word_done
);

  localparam logic [1:0] LastByte = 2'(BYTES_PER_WORD - 1);

  logic [1:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] word_q, word_d;

  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clear) begin
      cnt_d = '0;
    end else if (in_valid) begin
      word_d[{cnt_q, 3'b000} +: 8] = in_data;
      cnt_d = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  assign word      = word_d;
  assign word_done = in_valid && !clear
                  && (cnt_q == LastByte);

endmodule

// File: rtl/boot_loader.sv
// Loads count/words/checksum from a byte stream into memory,
// then hands the shared bus to the SUBLEQ core via cpu_en.
module boot_loader
  import boot_pkg::*;
#(
  parameter logic [WORD_W-1:0] BASE_ADDR = 32'h0,
  parameter int unsigned       MAX_WORDS = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              reload,
  output logic              cpu_en,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  inout  wire  [WORD_W-1:0] mem_data,
  output logic              busy,
  output logic              err
);

  localparam logic [WORD_W-1:0] MaxW = WORD_W'(MAX_WORDS);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] count_q, count_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [WORD_W-1:0] csum_q, csum_d;
  logic [WORD_W-1:0] idx_q, idx_d;
  logic [WORD_W-1:0] addr_q, addr_d;

  logic              pk_valid;
  logic              pk_done;
  logic [WORD_W-1:0] pk_word;
  logic              we;

  // A byte arriving with reload is dropped.
  assign pk_valid = rx_valid && rx_ready && !reload;

  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (pk_valid),
    .in_data   (rx_data),
    .clear     (reload),
    .word      (pk_word),
    .word_done (pk_done)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    word_d  = word_q;
    csum_d  = csum_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    unique case (state_q)
      S_HDR: begin
        if (pk_done) begin
          count_d = pk_word;
          if (pk_word == '0)
            state_d = S_CSUM;
          else if (pk_word > MaxW)
            state_d = S_ERR;
          else
            state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (pk_done) begin
          word_d  = pk_word;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        csum_d  = csum_q ^ word_q;
        idx_d   = idx_q + 32'd1;
        addr_d  = addr_q + 32'd4;
        state_d = (idx_d < count_q) ? S_DATA
                                    : S_CSUM;
      end
      S_CSUM: begin
        if (pk_done) begin
          word_d  = pk_word;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        state_d = (word_q == csum_q) ? S_RUN
                                     : S_ERR;
      end
      S_RUN, S_ERR: begin
        state_d = state_q;
      end
      default: begin
        state_d = S_HDR;
      end
    endcase
    if (reload) begin
      state_d = S_HDR;
      idx_d   = '0;
      csum_d  = '0;
      addr_d  = BASE_ADDR;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_HDR;
      count_q <= '0;
      word_q  <= '0;
      csum_q  <= '0;
      idx_q   <= '0;
      addr_q  <= BASE_ADDR;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      word_q  <= word_d;
      csum_q  <= csum_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    rx_ready = 1'b0;
    busy     = 1'b0;
    err      = 1'b0;
    cpu_en   = 1'b0;
    we       = 1'b0;
    unique case (1'b1)
      (state_q == S_HDR),
      (state_q == S_DATA),
      (state_q == S_CSUM): begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
      (state_q == S_WRITE): begin
        busy = 1'b1;
        we   = 1'b1;
      end
      (state_q == S_CHECK): busy   = 1'b1;
      (state_q == S_RUN):   cpu_en = 1'b1;
      (state_q == S_ERR):   err    = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Release and cpu_en both decode from state_q, so they flip together.
  assign mem_we   = cpu_en ? 1'bz : we;
  assign mem_addr = cpu_en ? {WORD_W{1'bz}} : addr_q;
  assign mem_data = (!cpu_en && we) ? word_q
                                    : {WORD_W{1'bz}};

endmodule
